conv2d_stream: RTL and testbench
================================

Name: conv2d_stream

Overview:
Parametrised streaming 2-D convolution layer, the successor to the fixed-geometry convolution_2D. It accepts one pixel per cycle under a valid qualifier and tracks row and column position in the frame. It gates out edge windows, so only fully populated K×K windows produce results. It applies NUM_K kernels in parallel through pipelined multiply-adder trees and emits one result per kernel with out_valid and frame_done markers. It sits between the pixel source and the next layer's line buffer.

Parameters:
DATA_W, 8, pixel and kernel element width (unsigned).
K, 4, square kernel edge; K*K taps per kernel; K >= 2.
IMG_W, 6, pixels per image row; IMG_W >= K.
IMG_H, 6, rows per frame; IMG_H >= K.
NUM_K, 2, parallel kernels / output channels.
OUT_W, 32, width of each output channel; OUT_W <= SUM_W.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-low reset.
pixel_in  in  DATA_W  streamed pixel, raster order.
pixel_valid  in  1  pixel_in is accepted on this edge.
sof  in  1  start of frame; qualified by pixel_valid.
kernel  in  DATA_W*K*K*NUM_K  kernel weights; byte n*K*K + r*K + c = kernel n, tap (r,c).
pixel_out  out  OUT_W*NUM_K  results; channel n at bits [n*OUT_W +: OUT_W].
out_valid  out  1  pixel_out holds a new window result this cycle.
frame_done  out  1  coincident with out_valid of the last window of the frame.

Behaviour:
- Reset (async, low): col/row counters = 0; window register, pipeline valid bits, pixel_out, out_valid and frame_done all = 0. Line-buffer storage is not cleared, because the validity gating makes stale data unobservable. Reset mid-frame discards all in-flight windows; the next accepted pixel is (0,0).
- Accept: on an edge with pixel_valid=1, the pixel is shifted into the line buffer and the window. The column counter advances, wrapping at IMG_W-1 and incrementing the row. The row wraps at IMG_H-1. With pixel_valid=0, nothing shifts and the counters hold.
- sof: pixel_valid&&sof forces the accepted pixel to (0,0), whatever the counters say. sof without pixel_valid is ignored.
- Window taps: tap (0,0) is the newest pixel. Tap (r,c) is the pixel r rows above and c columns left of it. Line buffer: K-1 rows of IMG_W-deep delay.
- Window validity: tag = pixel_valid && col >= K-1 && row >= K-1, using the position of the accepted pixel. Untagged windows flow through the pipeline but never raise out_valid.
- Pipeline: one window register, one product register stage, then T = clog2(K*K) registered adder-tree levels, then the output register. LAT = 2 + T edges. out_valid goes high after edge t+LAT for a window accepted on edge t (LAT=6 at defaults). The pipeline never stalls; gaps in pixel_valid become gaps in out_valid.
- Kernel is sampled at the product stage. It must be held stable while tagged windows are in flight; changes take effect per window.
- Arithmetic: unsigned. Products are 2*DATA_W bits; sums are SUM_W = 2*DATA_W + clog2(K*K) bits with no overflow. The output reduction from SUM_W to OUT_W is set by the optional feature.
- pixel_out holds its last value while out_valid=0. out_valid and frame_done are one-cycle pulses per tagged window.
- frame_done=1 only with the out_valid of the window whose pixel is (IMG_H-1, IMG_W-1).

Optional Feature:
Macro CONV2D_STREAM_SAT_EN.
- Defined: each channel saturates; if sum > 2^OUT_W-1, output is 2^OUT_W-1, otherwise the sum.
- Undefined: output is sum[OUT_W-1:0] (truncation).
- When OUT_W = SUM_W, both modes are identical.

Decomposition:
- Package conv2d_pkg: clog2 function; SUM_W and LAT derivation functions; tap_index(n,r,c) function; shared typedef for the unsigned pixel word.
- Sub-module conv2d_line_buffer: K-1 row delays plus the K×K window register and the col/row counters with sof handling. It outputs the flattened window and the tag.
- The top level instantiates one line buffer and NUM_K multiply-adder trees.

Test Plan:
Defaults, pixel_in = accept count 0,1,2,… every cycle, sof on the first pixel.
- Kernel 1 rows (r=0..3) 2,2,1,1 / 2,2,1,1 / 1,1,2,2 / 1,1,2,2 (listed c=0..3); kernel 2 rows all 2,2,3,3. Response: first out_valid LAT=6 edges after pixel 21 is accepted, with ch0=252 and ch1=412. The next cycle gives ch0=276 and ch1=452.
- Same stream: out_valid is low for the windows at pixels 24..26 (col<3) and high again at pixel 27. frame_done pulses exactly once, at pixel 35's result. Total out_valid count per frame = 9.
- Toggle pixel_valid 1,0,1,0…: the results 252/412 then 276/452 appear with gaps matching the input gaps, and pixel_out holds between pulses.
- OUT_W=8, same kernels: with CONV2D_STREAM_SAT_EN, ch0=252 and ch1=255. Without it, ch0=252 and ch1=156.
- Assert reset for one cycle while pixel 22 is in flight: all outputs are 0 and no stale out_valid appears. Restart with sof: first result again 252/412 at pixel 21.
- Raise sof mid-frame at count 10: counters resync. The first out_valid comes at the 22nd pixel after the resync, and no out_valid appears for windows straddling the resync.

Source files
------------

// File: rtl/conv2d_pkg.sv
// Shared helpers and types for the conv2d_stream convolution layer:
// width/latency derivation, kernel tap indexing and the default pixel word.
package conv2d_pkg;

  localparam int PIXEL_W = 8;

  typedef logic [PIXEL_W-1:0] pixel_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Accumulator width that can hold K*K full-scale products without overflow
  function automatic int sum_w(input int data_w, input int k);
    return 2 * data_w + clog2(k * k);
  endfunction

  function automatic int lat_of(input int k);
    return 2 + clog2(k * k);
  endfunction

  function automatic int tap_index(input int k, input int n, input int r, input int c);
    return n * k * k + r * k + c;
  endfunction

endpackage

// File: rtl/conv2d_line_buffer.sv
// Line buffer for conv2d_stream: K-1 row delays, the K x K window register,
// raster col/row tracking with sof resync, and the window validity tag.
module conv2d_line_buffer
  import conv2d_pkg::*;
#(
  parameter int DATA_W = PIXEL_W,
  parameter int K      = 4,
  parameter int IMG_W  = 6,
  parameter int IMG_H  = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     pixel_in,
  input  logic                  pixel_valid,
  input  logic                  sof,
  output logic [DATA_W*K*K-1:0] window,
  output logic                  tag,
  output logic                  last
);

  localparam int CW_C = clog2(IMG_W);
  localparam int CW_R = clog2(IMG_H);

  logic [CW_C-1:0]   col_r, col_s, col_nxt_s;
  logic [CW_R-1:0]   row_r, row_s, row_nxt_s;
  logic [DATA_W-1:0] line_r [K-1][IMG_W];
  logic [DATA_W-1:0] row_in_s [K];
  logic [DATA_W-1:0] win_r [K*K];
  logic              tag_r, last_r;

  // Position of the pixel offered this cycle (sof forces the origin) and its successor
  always_comb begin
    if (sof) begin
      col_s = {CW_C{1'b0}};
      row_s = {CW_R{1'b0}};
    end else begin
      col_s = col_r;
      row_s = row_r;
    end
    if (col_s == CW_C'(IMG_W - 1)) begin
      col_nxt_s = {CW_C{1'b0}};
      if (row_s == CW_R'(IMG_H - 1)) begin
        row_nxt_s = {CW_R{1'b0}};
      end else begin
        row_nxt_s = row_s + CW_R'(1);
      end
    end else begin
      col_nxt_s = col_s + CW_C'(1);
      row_nxt_s = row_s;
    end
  end

  // Row r of the window is fed by the pixel accepted r*IMG_W accepts ago
  always_comb begin
    row_in_s[0] = pixel_in;
    for (int r = 1; r < K; r++) begin
      row_in_s[r] = line_r[r-1][IMG_W-1];
    end
  end

  // Row delay storage is not cleared: the tag keeps stale contents unobservable
  always_ff @(posedge clock) begin
    if (pixel_valid) begin
      for (int r = 0; r < K - 1; r++) begin
        line_r[r][0] <= row_in_s[r];
        for (int i = 1; i < IMG_W; i++) begin
          line_r[r][i] <= line_r[r][i-1];
        end
      end
    end
  end

  // Counters, window shift and tag/last flags for the accepted pixel
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_r  <= {CW_C{1'b0}};
      row_r  <= {CW_R{1'b0}};
      tag_r  <= 1'b0;
      last_r <= 1'b0;
      for (int i = 0; i < K * K; i++) begin
        win_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      tag_r  <= pixel_valid && (col_s >= CW_C'(K - 1)) && (row_s >= CW_R'(K - 1));
      last_r <= pixel_valid && (col_s == CW_C'(IMG_W - 1)) && (row_s == CW_R'(IMG_H - 1));
      if (pixel_valid) begin
        col_r <= col_nxt_s;
        row_r <= row_nxt_s;
        for (int r = 0; r < K; r++) begin
          win_r[r*K] <= row_in_s[r];
          for (int c = 1; c < K; c++) begin
            win_r[r*K+c] <= win_r[r*K+c-1];
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < K * K; i++) begin
      window[i*DATA_W +: DATA_W] = win_r[i];
    end
  end

  assign tag  = tag_r;
  assign last = last_r;

endmodule

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming K x K convolution with NUM_K parallel pipelined multiply-adder trees.
// Define CONV2D_STREAM_SAT_EN to saturate each channel to OUT_W bits instead of truncating.
module conv2d_stream
  import conv2d_pkg::*;
#(
  parameter int DATA_W = PIXEL_W,
  parameter int K      = 4,
  parameter int IMG_W  = 6,
  parameter int IMG_H  = 6,
  parameter int NUM_K  = 2,
  parameter int OUT_W  = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           pixel_in,
  input  logic                        pixel_valid,
  input  logic                        sof,
  input  logic [DATA_W*K*K*NUM_K-1:0] kernel,
  output logic [OUT_W*NUM_K-1:0]      pixel_out,
  output logic                        out_valid,
  output logic                        frame_done
);

  localparam int TAPS   = K * K;
  localparam int T      = clog2(TAPS);
  localparam int LEAVES = 1 << T;
  localparam int NODES  = 2 * LEAVES - 1;
  localparam int SUM_W  = sum_w(DATA_W, K);

  logic [DATA_W*TAPS-1:0] window_s;
  logic                   tag_s, last_s;
  logic [T:0]             vld_r, lst_r;
  logic                   out_valid_r, frame_done_r;

  conv2d_line_buffer #(
    .DATA_W (DATA_W),
    .K      (K),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H)
  ) u_line_buffer (
    .clock       (clock),
    .reset       (reset),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .sof         (sof),
    .window      (window_s),
    .tag         (tag_s),
    .last        (last_s)
  );

  // Tag and last-window flags ride alongside the product and adder-tree stages
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_r        <= {(T+1){1'b0}};
      lst_r        <= {(T+1){1'b0}};
      out_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      vld_r        <= {vld_r[T-1:0], tag_s};
      lst_r        <= {lst_r[T-1:0], last_s};
      out_valid_r  <= vld_r[T];
      frame_done_r <= vld_r[T] && lst_r[T];
    end
  end

  for (genvar n = 0; n < NUM_K; n++) begin : g_kernel
    logic [2*DATA_W-1:0] prod_s [TAPS];
    logic [SUM_W-1:0]    node_r [NODES];
    logic [OUT_W-1:0]    res_s;
    logic [OUT_W-1:0]    ch_r;

    // The kernel is sampled here, one edge after the window is captured
    always_comb begin
      for (int i = 0; i < TAPS; i++) begin
        prod_s[i] = {{DATA_W{1'b0}}, window_s[i*DATA_W +: DATA_W]} *
                    {{DATA_W{1'b0}}, kernel[tap_index(K, n, i / K, i % K)*DATA_W +: DATA_W]};
      end
    end

    // Heap-ordered tree: leaves at LEAVES-1.., node i sums children 2i+1 and 2i+2
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < NODES; i++) begin
          node_r[i] <= {SUM_W{1'b0}};
        end
      end else begin
        for (int i = 0; i < TAPS; i++) begin
          node_r[LEAVES-1+i] <= {{(SUM_W-2*DATA_W){1'b0}}, prod_s[i]};
        end
        for (int i = TAPS; i < LEAVES; i++) begin
          node_r[LEAVES-1+i] <= {SUM_W{1'b0}};
        end
        for (int i = 0; i < LEAVES - 1; i++) begin
          node_r[i] <= node_r[2*i+1] + node_r[2*i+2];
        end
      end
    end

`ifdef CONV2D_STREAM_SAT_EN
    if (OUT_W < SUM_W) begin : g_sat
      always_comb begin
        if (|node_r[0][SUM_W-1:OUT_W]) begin
          res_s = {OUT_W{1'b1}};
        end else begin
          res_s = node_r[0][OUT_W-1:0];
        end
      end
    end else begin : g_full
      assign res_s = node_r[0][OUT_W-1:0];
    end
`else
    assign res_s = node_r[0][OUT_W-1:0];
`endif

    // Channel result holds between valid windows
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        ch_r <= {OUT_W{1'b0}};
      end else if (vld_r[T]) begin
        ch_r <= res_s;
      end else begin
        ch_r <= ch_r;
      end
    end

    assign pixel_out[n*OUT_W +: OUT_W] = ch_r;
  end

  assign out_valid  = out_valid_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_conv2d_stream.sv
// Scoreboard bench for conv2d_stream: a frame-array reference model queues expected
// results with their due cycle; monitors for a 32-bit and an 8-bit output instance compare.
module tb_conv2d_stream;
  import conv2d_pkg::*;

  localparam int DW  = 8;
  localparam int K   = 4;
  localparam int IW  = 6;
  localparam int IH  = 6;
  localparam int NK  = 2;
  localparam int OW  = 32;
  localparam int OW8 = 8;
  localparam int NT  = K * K;
  localparam int LAT = 2 + $clog2(NT);
  localparam int WIN_PER_FRAME = (IW - K + 1) * (IH - K + 1);
`ifdef CONV2D_STREAM_SAT_EN
  localparam logic [63:0] EXP8_CH1 = 64'd255;
`else
  localparam logic [63:0] EXP8_CH1 = 64'd156;
`endif

  typedef struct packed {
    int                   due;
    logic                 last;
    logic [NK-1:0][31:0]  sum;
  } exp_t;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  pixel_t               pixel_in = '0;
  logic                 pixel_valid = 1'b0;
  logic                 sof = 1'b0;
  logic [DW*NT*NK-1:0]  kernel = '0;
  logic [OW*NK-1:0]     pixel_out;
  logic                 out_valid, frame_done;
  logic [OW8*NK-1:0]    pixel_out8;
  logic                 out_valid8, frame_done8;

  int   n_cmp = 0, n_bad = 0, cyc = 0;
  int   n_valid = 0, n_fd = 0;
  int   img [IH][IW];
  int   mrow = 0, mcol = 0;
  exp_t q32[$], q8[$];
  logic [OW*NK-1:0]  seen[$];
  logic [OW8*NK-1:0] seen8[$];
  logic [OW*NK-1:0]  held32 = '0;
  logic [OW8*NK-1:0] held8 = '0;

  conv2d_stream #(.DATA_W(DW), .K(K), .IMG_W(IW), .IMG_H(IH), .NUM_K(NK), .OUT_W(OW)) dut (
    .clock(clock), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid), .sof(sof),
    .kernel(kernel), .pixel_out(pixel_out), .out_valid(out_valid), .frame_done(frame_done));

  conv2d_stream #(.DATA_W(DW), .K(K), .IMG_W(IW), .IMG_H(IH), .NUM_K(NK), .OUT_W(OW8)) dut8 (
    .clock(clock), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid), .sof(sof),
    .kernel(kernel), .pixel_out(pixel_out8), .out_valid(out_valid8), .frame_done(frame_done8));

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic logic [63:0] red8(input logic [31:0] s);
`ifdef CONV2D_STREAM_SAT_EN
    return (s > 32'd255) ? 64'd255 : {32'd0, s};
`else
    return {56'd0, s[7:0]};
`endif
  endfunction

  function automatic int weight(input int n, input int r, input int c);
    return int'(kernel[(n*NT + r*K + c)*DW +: DW]);
  endfunction

  // One cycle of stimulus; the model records the pixel at its frame position
  task automatic drive(input logic pv, input logic s, input int pix);
    exp_t e;
    int   acc;
    @(negedge clock);
    pixel_valid = pv;
    sof         = s;
    pixel_in    = DW'(pix);
    if (pv) begin
      if (s) begin
        mrow = 0;
        mcol = 0;
      end
      img[mrow][mcol] = pix;
      if (mrow >= K - 1 && mcol >= K - 1) begin
        e.due  = cyc + 1 + LAT;
        e.last = (mrow == IH - 1) && (mcol == IW - 1);
        for (int n = 0; n < NK; n++) begin
          acc = 0;
          for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
              acc += img[mrow-r][mcol-c] * weight(n, r, c);
          e.sum[n] = 32'(acc);
        end
        q32.push_back(e);
        q8.push_back(e);
      end
      mcol++;
      if (mcol == IW) begin
        mcol = 0;
        mrow = (mrow + 1) % IH;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0);
  endtask

  task automatic feed(input int n, input int base, input bit gaps);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, i == 0, base + i);
      if (gaps) drive(1'b0, 1'b0, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset       = 1'b0;
    pixel_valid = 1'b0;
    sof         = 1'b0;
    q32.delete();
    q8.delete();
    mrow = 0;
    mcol = 0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic set_directed_kernel();
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        kernel[(0*NT + r*K + c)*DW +: DW] = (r < 2) ? ((c < 2) ? 8'd2 : 8'd1) : ((c < 2) ? 8'd1 : 8'd2);
        kernel[(1*NT + r*K + c)*DW +: DW] = (c < 2) ? 8'd2 : 8'd3;
      end
  endtask

  // Full-width monitor
  always @(posedge clock) begin
    exp_t e;
    logic ev;
    #2;
    if (!reset) begin
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_pixel_out", pixel_out, 64'd0);
      chk("reset_frame_done", {63'd0, frame_done}, 64'd0);
      held32 = '0;
    end else begin
      ev = (q32.size() > 0) && (q32[0].due == cyc);
      chk("out_valid", {63'd0, out_valid}, {63'd0, ev});
      if (ev) begin
        e = q32.pop_front();
        for (int n = 0; n < NK; n++)
          chk($sformatf("ch%0d", n), {32'd0, pixel_out[n*OW +: OW]}, {32'd0, e.sum[n]});
        chk("frame_done", {63'd0, frame_done}, {63'd0, e.last});
      end else begin
        chk("hold", pixel_out, held32);
        chk("frame_done_idle", {63'd0, frame_done}, 64'd0);
      end
      if (out_valid) begin
        held32 = pixel_out;
        seen.push_back(pixel_out);
        n_valid++;
      end
      if (frame_done) n_fd++;
    end
  end

  // Reduced-width monitor
  always @(posedge clock) begin
    exp_t e;
    logic ev;
    #2;
    if (!reset) begin
      chk("reset_out_valid8", {63'd0, out_valid8}, 64'd0);
      chk("reset_pixel_out8", {48'd0, pixel_out8}, 64'd0);
      held8 = '0;
    end else begin
      ev = (q8.size() > 0) && (q8[0].due == cyc);
      chk("out_valid8", {63'd0, out_valid8}, {63'd0, ev});
      if (ev) begin
        e = q8.pop_front();
        for (int n = 0; n < NK; n++)
          chk($sformatf("ch%0d_8", n), {56'd0, pixel_out8[n*OW8 +: OW8]}, red8(e.sum[n]));
        chk("frame_done8", {63'd0, frame_done8}, {63'd0, e.last});
      end else begin
        chk("hold8", {48'd0, pixel_out8}, {48'd0, held8});
      end
      if (out_valid8) begin
        held8 = pixel_out8;
        seen8.push_back(pixel_out8);
      end
    end
  end

  task automatic check_first_pair(input string tag, input logic [63:0] c0, input logic [63:0] c1);
    chk({tag, "_n_results"}, 64'(seen.size()), 64'(WIN_PER_FRAME));
    if (seen.size() >= 2) begin
      chk({tag, "_first_ch0"}, {32'd0, seen[0][31:0]}, c0);
      chk({tag, "_first_ch1"}, {32'd0, seen[0][63:32]}, c1);
      chk({tag, "_second_ch0"}, {32'd0, seen[1][31:0]}, c0 + 64'd24);
      chk({tag, "_second_ch1"}, {32'd0, seen[1][63:32]}, c1 + 64'd40);
    end
  endtask

  initial begin
    int fd0, nv0;
    #1 reset = 1'b0;
    set_directed_kernel();
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Continuous frame with the reference kernels
    seen.delete(); seen8.delete(); fd0 = n_fd;
    feed(36, 0, 1'b0);
    idle(LAT + 3);
    check_first_pair("cont", 64'd252, 64'd412);
    chk("cont_frame_done_count", 64'(n_fd - fd0), 64'd1);
    if (seen8.size() >= 1) begin
      chk("narrow_ch0", {56'd0, seen8[0][7:0]}, 64'd252);
      chk("narrow_ch1", {56'd0, seen8[0][15:8]}, EXP8_CH1);
    end else begin
      chk("narrow_results", 64'(seen8.size()), 64'd1);
    end

    // Alternating pixel_valid
    seen.delete();
    feed(36, 0, 1'b1);
    idle(LAT + 3);
    check_first_pair("gaps", 64'd252, 64'd412);

    // Reset while windows 21 and 22 are in flight
    feed(23, 0, 1'b0);
    do_reset();
    nv0 = n_valid;
    idle(LAT + 3);
    chk("no_stale_valid", 64'(n_valid - nv0), 64'd0);
    seen.delete();
    feed(36, 0, 1'b0);
    idle(LAT + 3);
    check_first_pair("after_reset", 64'd252, 64'd412);

    // sof mid-frame at count 10
    seen.delete();
    feed(10, 0, 1'b0);
    feed(36, 10, 1'b0);
    idle(LAT + 3);
    check_first_pair("resync", 64'd492, 64'd812);

    // Random kernels, pixels, gaps and occasional sof
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NT * NK; i++) kernel[i*DW +: DW] = DW'($urandom);
      drive(1'b1, 1'b1, int'($urandom_range(0, 255)));
      for (int i = 0; i < 120; i++)
        drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0), int'($urandom_range(0, 255)));
      idle(LAT + 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
